ifid_skid_reg: RTL and testbench

Parametrised IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer. It sits between the fetch stage (PC adder plus instruction memory) and decode. It replaces the plain stall/flush latch with backpressure that never drops a fetched instruction. It also adds NOP insertion on flush and saturating bubble and flush counters for performance monitoring.

---
 rtl/ifid_skid_reg.sv | 131 +++++++++++++
 tb/tb_ifid_skid_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, two-entry skid buffer,
// NOP insertion on flush and saturating bubble/flush performance counters.
module ifid_skid_reg #(
  parameter int                 PC_W     = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     head_pc_q, skid_pc_q;
  logic [INST_W-1:0]   head_inst_q, skid_inst_q;
  logic [CNT_W-1:0]    bubble_cnt_q, flush_cnt_q;

  logic up_acc, dn_acc;
  logic head_ld_in, head_ld_skid, head_clr, skid_ld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign valid_o = (state_q != EMPTY);
  assign ready_o = (state_q != FULL);
  assign up_acc  = valid_i & ready_o;
  assign dn_acc  = valid_o & ready_i & ~stall_i;

  always_comb begin
    state_d      = state_q;
    head_ld_in   = 1'b0;
    head_ld_skid = 1'b0;
    head_clr     = 1'b0;
    skid_ld      = 1'b0;
    if (flush_i) begin
      // Everything held or accepted this cycle is squashed.
      state_d  = EMPTY;
      head_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_acc) begin
            state_d    = ONE;
            head_ld_in = 1'b1;
          end
        end
        ONE: begin
          if (up_acc && dn_acc) begin
            head_ld_in = 1'b1;
          end else if (up_acc) begin
            state_d = FULL;
            skid_ld = 1'b1;
          end else if (dn_acc) begin
            state_d  = EMPTY;
            head_clr = 1'b1;
          end
        end
        FULL: begin
          if (dn_acc) begin
            state_d      = ONE;
            head_ld_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head/skid storage; emptying keeps the last PC but shows NOP.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_pc_q   <= '0;
      head_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
    end else begin
      if (head_ld_in) begin
        head_pc_q   <= pc_i;
        head_inst_q <= inst_i;
      end else if (head_ld_skid) begin
        head_pc_q   <= skid_pc_q;
        head_inst_q <= skid_inst_q;
      end else if (head_clr) begin
        head_inst_q <= NOP_INST;
      end
      if (skid_ld) begin
        skid_pc_q   <= pc_i;
        skid_inst_q <= inst_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (!valid_o) bubble_cnt_q <= sat_inc(bubble_cnt_q);
      if (flush_i)  flush_cnt_q  <= sat_inc(flush_cnt_q);
    end
  end

  assign pc_o         = head_pc_q;
  assign inst_o       = head_inst_q;
  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed bench for ifid_skid_reg: streaming, backpressure, stall, flush,
// counter saturation (CNT_W=3 instance) and asynchronous reset.
module tb_ifid_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, ready_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [31:0] pc_i = '0, inst_i = '0;
  logic        ready_o, valid_o;
  logic [31:0] pc_o, inst_o;
  logic [15:0] bubble_cnt, flush_cnt;
  logic        ready3, valid3;
  logic [31:0] pc3, inst3;
  logic [2:0]  bubble3, flush3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ifid_skid_reg #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .valid_o(valid_o), .ready_i(ready_i),
    .stall_i(stall_i), .flush_i(flush_i), .pc_o(pc_o), .inst_o(inst_o),
    .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
  );

  ifid_skid_reg #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready3),
    .pc_i(pc_i), .inst_i(inst_i), .valid_o(valid3), .ready_i(ready_i),
    .stall_i(stall_i), .flush_i(flush_i), .pc_o(pc3), .inst_o(inst3),
    .bubble_cnt_o(bubble3), .flush_cnt_o(flush3)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    valid_i = v;
    pc_i    = pc;
    inst_i  = inst_of(pc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0);
    ready_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", ready_o); end
    tests++; if (pc_o !== 32'd0) begin fails++; $display("FAIL reset_pc: got %0h want 0", pc_o); end
    tests++; if (inst_o !== NOP) begin fails++; $display("FAIL reset_inst: got %0h want %0h", inst_o, NOP); end
    tests++; if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bubble_cnt, flush_cnt); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [4] = '{32'd4, 32'd8, 32'd12, 32'd16};
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pcs[i]);
      step();
      tests++; if (valid_o !== 1'b1 || pc_o !== pcs[i] || inst_o !== inst_of(pcs[i])) begin
        fails++; $display("FAIL stream_beat%0d: got v=%0b pc=%0h inst=%0h want v=1 pc=%0h inst=%0h", i, valid_o, pc_o, inst_o, pcs[i], inst_of(pcs[i]));
      end
    end
    tests++; if (bubble_cnt !== 16'd1) begin fails++; $display("FAIL stream_bubble: got %0d want 1", bubble_cnt); end
    drive(1'b0, 32'd0);
    step();
    tests++; if (valid_o !== 1'b0 || inst_o !== NOP || pc_o !== 32'd16 || ready_o !== 1'b1) begin
      fails++; $display("FAIL stream_drain: got v=%0b inst=%0h pc=%0h rdy=%0b want v=0 inst=%0h pc=10 rdy=1", valid_o, inst_o, pc_o, ready_o, NOP);
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b1;
    drive(1'b1, 32'd4);
    step();
    ready_i = 1'b0;
    drive(1'b1, 32'd8);
    step();
    tests++; if (ready_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'd4) begin
      fails++; $display("FAIL bp_full: got rdy=%0b v=%0b pc=%0h want rdy=0 v=1 pc=4", ready_o, valid_o, pc_o);
    end
    drive(1'b1, 32'd12);
    step();
    tests++; if (ready_o !== 1'b0 || pc_o !== 32'd4) begin
      fails++; $display("FAIL bp_hold: got rdy=%0b pc=%0h want rdy=0 pc=4", ready_o, pc_o);
    end
    ready_i = 1'b1;
    step();
    tests++; if (ready_o !== 1'b1 || pc_o !== 32'd8 || inst_o !== inst_of(32'd8)) begin
      fails++; $display("FAIL bp_drain: got rdy=%0b pc=%0h inst=%0h want rdy=1 pc=8 inst=%0h", ready_o, pc_o, inst_o, inst_of(32'd8));
    end
    step();
    tests++; if (pc_o !== 32'd12 || valid_o !== 1'b1) begin fails++; $display("FAIL bp_beat12: got pc=%0h v=%0b want pc=c v=1", pc_o, valid_o); end
    drive(1'b1, 32'd16);
    step();
    tests++; if (pc_o !== 32'd16 || valid_o !== 1'b1) begin fails++; $display("FAIL bp_beat16: got pc=%0h v=%0b want pc=10 v=1", pc_o, valid_o); end
    drive(1'b0, 32'd0);
    step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL bp_empty: got v=%0b want 0", valid_o); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'd20);
    step();
    stall_i = 1'b1;
    drive(1'b0, 32'd0);
    repeat (2) step();
    tests++; if (valid_o !== 1'b1 || pc_o !== 32'd20 || inst_o !== inst_of(32'd20)) begin
      fails++; $display("FAIL stall_hold: got v=%0b pc=%0h inst=%0h want v=1 pc=14 inst=%0h", valid_o, pc_o, inst_o, inst_of(32'd20));
    end
    stall_i = 1'b0;
    drive(1'b1, 32'd24);
    step();
    tests++; if (pc_o !== 32'd24 || valid_o !== 1'b1) begin fails++; $display("FAIL stall_release: got pc=%0h v=%0b want pc=18 v=1", pc_o, valid_o); end
    drive(1'b0, 32'd0);
    step();
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    drive(1'b1, 32'd28);
    step();
    drive(1'b1, 32'd32);
    step();
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL flush_prefull: got rdy=%0b want 0", ready_o); end
    flush_i = 1'b1;
    drive(1'b1, 32'd36);
    step();
    flush_i = 1'b0;
    tests++; if (valid_o !== 1'b0 || inst_o !== NOP || ready_o !== 1'b1 || pc_o !== 32'd28 || flush_cnt !== 16'd1) begin
      fails++; $display("FAIL flush_full: got v=%0b inst=%0h rdy=%0b pc=%0h fcnt=%0d want v=0 inst=%0h rdy=1 pc=1c fcnt=1", valid_o, inst_o, ready_o, pc_o, flush_cnt, NOP);
    end
    ready_i = 1'b1;
    drive(1'b0, 32'd0);
    step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_no_ghost: got v=%0b pc=%0h want v=0", valid_o, pc_o); end
    drive(1'b1, 32'd40);
    step();
    tests++; if (pc_o !== 32'd40 || valid_o !== 1'b1) begin fails++; $display("FAIL flush_next: got pc=%0h v=%0b want pc=28 v=1", pc_o, valid_o); end
    flush_i = 1'b1;
    stall_i = 1'b1;
    drive(1'b1, 32'd44);
    step();
    flush_i = 1'b0;
    stall_i = 1'b0;
    tests++; if (valid_o !== 1'b0 || inst_o !== NOP || flush_cnt !== 16'd2) begin
      fails++; $display("FAIL flush_stall: got v=%0b inst=%0h fcnt=%0d want v=0 inst=%0h fcnt=2", valid_o, inst_o, flush_cnt, NOP);
    end
    drive(1'b0, 32'd0);
    step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_accepted_dropped: got v=%0b pc=%0h want v=0", valid_o, pc_o); end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0;
    drive(1'b1, 32'd48);
    step();
    drive(1'b1, 32'd52);
    step();
    tests++; if (ready_o !== 1'b0 || pc_o !== 32'd48) begin fails++; $display("FAIL areset_prefull: got rdy=%0b pc=%0h want rdy=0 pc=30", ready_o, pc_o); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || pc_o !== 32'd0 || inst_o !== NOP || bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      fails++; $display("FAIL areset_now: got v=%0b rdy=%0b pc=%0h inst=%0h cnt=%0d/%0d want v=0 rdy=1 pc=0 inst=%0h cnt=0/0", valid_o, ready_o, pc_o, inst_o, bubble_cnt, flush_cnt, NOP);
    end
  endtask

  task automatic test_saturate();
    drive(1'b0, 32'd0);
    ready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    tests++; if (bubble3 !== 3'd6) begin fails++; $display("FAIL sat_mid: got %0d want 6", bubble3); end
    repeat (4) step();
    tests++; if (bubble3 !== 3'd7) begin fails++; $display("FAIL sat_cap: got %0d want 7", bubble3); end
    tests++; if (bubble_cnt !== 16'd10) begin fails++; $display("FAIL sat_wide: got %0d want 10", bubble_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
